// File: rtl/fifo_arb_pkg.sv
// Shared constants and FSM encoding for the round-robin fifo write arbiter.
package fifo_arb_pkg;
   localparam int N_REQ_DEF  = 4;
   localparam int DATA_W_DEF = 2;
   localparam int CNT_W      = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;
endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or above ptr, wrapping.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] elig,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] onehot,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);
   always_comb begin
      onehot = '0;
      valid  = 1'b0;
      idx    = '0;
      // Scan farthest offset first so the nearest eligible index is the last write.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (elig[(int'(ptr) + k) % N_REQ]) begin
            onehot = N_REQ'(1) << ((int'(ptr) + k) % N_REQ);
            valid  = 1'b1;
            idx    = IDX_W'((int'(ptr) + k) % N_REQ);
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one fifo write port among N_REQ requesters; all outputs registered.
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        gnt,
   output logic                    wr_e,
   output logic [DATA_W-1:0]       wr_data,
   input  logic                    busy,
   output logic [CNT_W-1:0]        wr_cnt
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [DATA_W-1:0]  wr_data_q, wr_data_d;
   logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic [N_REQ-1:0]   elig;
   logic [N_REQ-1:0]   pick_onehot;
   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic [DATA_W-1:0]  data_arr [N_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_slice
         assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // A requester granted last cycle still shows req this edge; mask it out.
   assign elig = req & ~gnt_q;

   rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
      .elig   (elig),
      .ptr    (rr_ptr_q),
      .onehot (pick_onehot),
      .valid  (pick_valid),
      .idx    (pick_idx)
   );

   always_comb begin
      state_d   = IDLE;
      gnt_d     = '0;
      wr_data_d = wr_data_q;
      wr_cnt_d  = wr_cnt_q;
      rr_ptr_d  = rr_ptr_q;
      if (pick_valid && !busy) begin
         state_d   = WRITE;
         gnt_d     = pick_onehot;
         wr_data_d = data_arr[pick_idx];
         wr_cnt_d  = wr_cnt_q + 1'b1;
         rr_ptr_d  = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         wr_data_q <= '0;
         wr_cnt_q  <= '0;
         rr_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         wr_data_q <= wr_data_d;
         wr_cnt_q  <= wr_cnt_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   assign wr_e    = (state_q == WRITE);
   assign gnt     = gnt_q;
   assign wr_data = wr_data_q;
   assign wr_cnt  = wr_cnt_q;
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed vector bench for fifo_wr_arb with N_REQ=4, DATA_W=2.
module tb_fifo_wr_arb;
   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [7:0] req_data;
   logic [3:0] gnt;
   logic       wr_e;
   logic [1:0] wr_data;
   logic       busy;
   logic [7:0] wr_cnt;

   int tests_run;
   int tests_failed;

   typedef struct {
      logic [3:0] req;
      logic       busy;
      logic       exp_we;
      logic [3:0] exp_gnt;
      logic [1:0] exp_wd;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs [17];

   fifo_wr_arb #(.N_REQ(4), .DATA_W(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .wr_e     (wr_e),
      .wr_data  (wr_data),
      .busy     (busy),
      .wr_cnt   (wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic we, input logic [3:0] g,
                            input logic [1:0] wd, input logic [7:0] c);
      check({tag, ".wr_e"}, 32'(wr_e), 32'(we));
      check({tag, ".gnt"}, 32'(gnt), 32'(g));
      check({tag, ".wr_data"}, 32'(wr_data), 32'(wd));
      check({tag, ".wr_cnt"}, 32'(wr_cnt), 32'(c));
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      // d3=01 d2=11 d1=00 d0=10
      req_data = 8'b01_11_00_10;
      req      = 4'b0000;
      busy     = 1'b0;
      rst      = 1'b1;

      //                req     busy  we    gnt      wd     cnt
      vecs[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00, 8'd0};
      vecs[1]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 2'b10, 8'd1};
      vecs[2]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 2'b10, 8'd1};
      vecs[3]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 2'b10, 8'd2};
      vecs[4]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 2'b00, 8'd3};
      vecs[5]  = '{4'b1111, 1'b0, 1'b1, 4'b0100, 2'b11, 8'd4};
      vecs[6]  = '{4'b1111, 1'b0, 1'b1, 4'b1000, 2'b01, 8'd5};
      vecs[7]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 2'b10, 8'd6};
      vecs[8]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 2'b10, 8'd6};
      vecs[9]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 2'b10, 8'd6};
      vecs[10] = '{4'b0100, 1'b1, 1'b0, 4'b0000, 2'b10, 8'd6};
      vecs[11] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2'b11, 8'd7};
      vecs[12] = '{4'b1000, 1'b0, 1'b1, 4'b1000, 2'b01, 8'd8};
      vecs[13] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 8'd8};
      vecs[14] = '{4'b1001, 1'b0, 1'b1, 4'b0001, 2'b10, 8'd9};
      vecs[15] = '{4'b1001, 1'b0, 1'b1, 4'b1000, 2'b01, 8'd10};
      vecs[16] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 8'd10};

      #2;
      check_all("reset_t2", 1'b0, 4'b0000, 2'b00, 8'd0);
      $display("[TB] reset t=2 wr_e=%0b gnt=%b wr_cnt=%0d", wr_e, gnt, wr_cnt);
      #2 rst = 1'b0;

      @(negedge clk);
      for (int i = 0; i < 17; i++) begin
         req  = vecs[i].req;
         busy = vecs[i].busy;
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_gnt,
                   vecs[i].exp_wd, vecs[i].exp_cnt);
         $display("[TB] vec%0d req=%b busy=%0b -> wr_e=%0b gnt=%b wr_data=%b wr_cnt=%0d",
                  i, req, busy, wr_e, gnt, wr_data, wr_cnt);
         @(negedge clk);
      end

      // Asynchronous reset in the middle of a write cycle.
      req = 4'b1111;
      @(posedge clk);
      #1;
      check("pre_rst.wr_e", 32'(wr_e), 32'(1));
      #2 rst = 1'b1;
      #1;
      check_all("async_rst", 1'b0, 4'b0000, 2'b00, 8'd0);
      $display("[TB] async reset mid-write -> wr_e=%0b gnt=%b wr_data=%b wr_cnt=%0d",
               wr_e, gnt, wr_data, wr_cnt);
      @(negedge clk);
      rst = 1'b0;

      // 256 back-to-back writes with full contention: pointer rotates, counter wraps.
      for (int k = 0; k < 256; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("wrap%0d.wr_e", k), 32'(wr_e), 32'(1));
         check($sformatf("wrap%0d.gnt", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
         if (k == 254) check("wrap.cnt255", 32'(wr_cnt), 32'(255));
      end
      check("wrap.cnt0", 32'(wr_cnt), 32'(0));
      check("wrap.wr_data", 32'(wr_data), 32'(2'b01));
      $display("[TB] 256 writes -> wr_cnt=%0d gnt=%b", wr_cnt, gnt);
      @(negedge clk);
      req = 4'b0000;
      @(posedge clk);
      #1;
      check_all("post_wrap_idle", 1'b0, 4'b0000, 2'b01, 8'd0);
      $display("[TB] idle after wrap -> wr_e=%0b gnt=%b wr_cnt=%0d", wr_e, gnt, wr_cnt);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of write requesters sharing one fifo write port.
REQ-002 Parameter DATA_W, default 2, fifo data width in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with the following ports:
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester write request, level; requester i on bit i.
- req_data  input  N_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W].
- gnt  output  N_REQ  one-hot grant pulse, high in the cycle requester i's data is written.
- wr_e  output  1  fifo write enable.
- wr_data  output  DATA_W  fifo write data.
- busy  input  1  fifo cannot accept a write.
- wr_cnt  output  8  total writes issued, wraps.

Function
REQ-004 All outputs SHALL be registered; there is no combinational path from any input to any output.
REQ-005 Arbitration latency SHALL be 1 cycle: eligible request sampled at edge E with busy=0 gives wr_e=1, wr_data, gnt in the cycle after E.
REQ-006 Requester i SHALL be eligible at an edge iff req[i]=1 and gnt[i]=0 at that edge; a just-granted requester is never regranted in the next cycle.
REQ-007 Requester handshake: hold req[i] and req_data[i] stable until gnt[i] is seen; drop req or present new data on the following edge.
REQ-008 Winner SHALL be the first eligible index searching upward from rr_ptr, modulo N_REQ.
REQ-009 On a grant to index i, rr_ptr SHALL become (i+1) mod N_REQ; otherwise it SHALL hold.
REQ-010 wr_data SHALL equal the winner's req_data slice captured at edge E; gnt SHALL be one-hot and coincide exactly with wr_e.
REQ-011 If busy=1 at edge E, the next cycle SHALL have wr_e=0 and gnt=0, and rr_ptr SHALL hold.
REQ-012 FSM states and transitions:
- IDLE (wr_e=0), WRITE (wr_e=1).
- Any state -> WRITE when an eligible request exists and busy=0.
- Any state -> IDLE otherwise.
- Back-to-back WRITE cycles are legal across different requesters.
REQ-013 wr_cnt SHALL increment by 1 in every WRITE cycle and wrap 255 -> 0 with no flag.
REQ-014 If no requester is eligible, outputs SHALL be wr_e=0 and gnt=0; wr_data SHALL hold its last value.

Reset
REQ-015 rst=1 SHALL immediately, without a clock edge, force wr_e=0, gnt=0, wr_data=0, wr_cnt=0, rr_ptr=0, state=IDLE.
REQ-016 Reset asserted during a WRITE cycle SHALL abort that write (wr_e drops asynchronously); the write is not counted or retried.
REQ-017 The first arbitration edge SHALL be the first rising edge with rst=0.

Structure
REQ-018 Shared package fifo_arb_pkg SHALL hold the FSM state encodings (IDLE=0, WRITE=1), the default N_REQ/DATA_W values, and the wr_cnt width constant (8).
REQ-019 Round-robin selection SHALL be a separate combinational sub-module rr_pick (inputs: eligible vector, rr_ptr; outputs: one-hot winner, valid, winner index).

Verification (N_REQ=4, DATA_W=2)
REQ-020 Reset: rst=1 for the first 4 time units -> wr_e=0, gnt=0000, wr_cnt=0 throughout; rst asserted mid-test forces these values without an edge.
REQ-021 Single requester: req=0001, data0=2'b10 held, busy=0 -> cycle+1: wr_e=1, wr_data=10, gnt=0001; cycle+2: wr_e=0; cycle+3: regrant.
REQ-022 Full contention: req=1111 held, busy=0 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles, wr_e=1 continuously, wr_cnt +1 per cycle.
REQ-023 Backpressure: req=0100, busy=1 for 3 cycles -> wr_e=0, gnt=0000; busy drops at edge E -> gnt=0100 in the cycle after E.
REQ-024 Pointer fairness: grant to 3, then req=1001 -> next grant is 0 (rr_ptr wrapped to 0).
REQ-025 Counter wrap: 256 writes from wr_cnt=0 -> wr_cnt returns to 0 with no other side effect.
